sync_fifo: RTL and testbench

Synchronous single-clock FIFO: the design-under-test at the far end of `fifo_if`. It accepts writes qualified by `write_en` and reads qualified by `read_en`, and reports `full`, `empty` and protocol-violation `error` back to the driver and monitor. All outputs are registered and change only on the rising clock edge, so the interface clocking blocks sample stable values with their 1-time-unit input skew.

---
 rtl/sync_fifo.sv | 75 +++++++
 tb/tb_sync_fifo.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered flags, registered read data and a protocol-error output.
// Build option SYNC_FIFO_STICKY_ERROR_EN: when defined, error latches until rst instead of pulsing.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             wr_ok;
  logic             rd_ok;
  logic             err_now;

  // A write into a full FIFO is legal when a read frees a slot in the same cycle.
  assign wr_ok   = write_en & (~full | read_en);
  assign rd_ok   = read_en & ~empty;
  assign err_now = (write_en & full & ~read_en) | (read_en & empty);

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage carries no reset; only pointers, flags and read data are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      data_out <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      error    <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) begin
        data_out <= mem[rp];
        rp       <= rp + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
`ifdef SYNC_FIFO_STICKY_ERROR_EN
      error <= error | err_now;
`else
      error <= err_now;
`endif
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo (WIDTH=8, DEPTH=16); honours SYNC_FIFO_STICKY_ERROR_EN.
module tb_sync_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       read_en = 1'b0;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       error;

  int total = 0;
  int bad   = 0;

  logic [7:0] q [$];
  logic [7:0] exp_dout = '0;
  logic       exp_err  = 1'b0;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .data_out(data_out), .full(full), .empty(empty),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dout"},  32'(data_out), 32'(exp_dout));
    chk({tag, ".full"},  32'(full),     32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty),    32'(q.size() == 0));
    chk({tag, ".error"}, 32'(error),    32'(exp_err));
  endtask

  // One clock of traffic; the queue model decides acceptance from pre-edge occupancy.
  task automatic step(input string tag, input logic we, input logic [7:0] din, input logic re);
    logic mfull, mempty, wok, rok, e;
    mfull  = (q.size() == DEPTH);
    mempty = (q.size() == 0);
    wok    = we && (!mfull || re);
    rok    = re && !mempty;
    e      = (we && mfull && !re) || (re && mempty);
    write_en = we;
    data_in  = din;
    read_en  = re;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    if (rok) exp_dout = q.pop_front();
    if (wok) q.push_back(din);
`ifdef SYNC_FIFO_STICKY_ERROR_EN
    exp_err = exp_err | e;
`else
    exp_err = e;
`endif
    chk_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_err  = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    chk_all("reset");

    // Read on empty
    step("rd_empty", 1'b0, 8'h00, 1'b1);
    step("idle0", 1'b0, 8'h00, 1'b0);

    // Fill, overflow, simultaneous on full, drain
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0);
    chk("full_after_fill", 32'(full), 32'd1);
    step("overflow", 1'b1, 8'hFF, 1'b0);
    step("idle1", 1'b0, 8'h00, 1'b0);
    step("both_full", 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1);
    chk("last_drain_a5", 32'(data_out), 32'h0000_00A5);
    chk("empty_after_drain", 32'(empty), 32'd1);

    // Simultaneous on empty
    step("both_empty", 1'b1, 8'h3C, 1'b1);
    step("rd_3c", 1'b0, 8'h00, 1'b1);
    chk("got_3c", 32'(data_out), 32'h0000_003C);

    // Wrap-around with interleaved pairs
    for (int i = 0; i < 40; i++) begin
      step("wrap_wr", 1'b1, 8'(8'h40 + i), 1'b0);
      step("wrap_rd", 1'b0, 8'h00, 1'b1);
    end

    // Random traffic
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    // Asynchronous reset mid-cycle after partial fill
    model_reset();
    rst = 1'b1; #1; rst = 1'b0;
    for (int i = 0; i < 5; i++) step("prefill", 1'b1, 8'(8'h90 + i), 1'b0);
    step("prefill_rd", 1'b0, 8'h00, 1'b1);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    #2 rst = 1'b0;
    step("post_rst_wr", 1'b1, 8'h77, 1'b0);
    step("post_rst_rd", 1'b0, 8'h00, 1'b1);

    // Error behaviour across later legal traffic (pulse or sticky per build)
    step("err_again", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step("legal_wr", 1'b1, 8'(8'hC0 + i), 1'b0);
      step("legal_rd", 1'b0, 8'h00, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
